// File: rtl/jk_universal_register.sv
// WIDTH-bit register bank where every mode is reduced to per-bit J/K drives;
// each bit is a JK cell, so load/shift/count/toggle all share one flop style.

module jk_universal_register_bit (
  input  logic clk,
  input  logic reset,
  input  logic rst_val,
  input  logic j,
  input  logic k,
  output logic q
);
  logic q_d, q_q;

  always_comb begin
    q_d = q_q;
    unique case ({j, k})
      2'b00: q_d = q_q;
      2'b01: q_d = 1'b0;
      2'b10: q_d = 1'b1;
      2'b11: q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) q_q <= rst_val;
    else        q_q <= q_d;
  end

  assign q = q_q;
endmodule

module jk_universal_register #(
  parameter int unsigned          WIDTH       = 8,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             tc,
  output logic             ovf
);
  localparam logic [2:0] M_HOLD = 3'b000, M_JK  = 3'b001, M_LOAD = 3'b010,
                         M_SHL  = 3'b011, M_SHR = 3'b100, M_UP   = 3'b101,
                         M_DOWN = 3'b110, M_TOG = 3'b111;

  logic [WIDTH-1:0] j_eff, k_eff;
  logic [WIDTH:0]   carry_up, borrow_dn;
  logic             ovf_d, ovf_q;

  // A counter bit toggles when every lower bit is 1 (up) or 0 (down).
  assign carry_up[0]  = 1'b1;
  assign borrow_dn[0] = 1'b1;
  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    assign carry_up[i+1]  = carry_up[i]  &  q[i];
    assign borrow_dn[i+1] = borrow_dn[i] & ~q[i];
  end

  always_comb begin
    j_eff = '0;
    k_eff = '0;
    if (en) begin
      unique case (mode)
        M_HOLD: ;
        M_JK:   begin j_eff = j;              k_eff = k;               end
        M_LOAD: begin j_eff = d;              k_eff = ~d;              end
        M_SHL:  begin j_eff = {q[WIDTH-2:0], ser_in};
                      k_eff = ~{q[WIDTH-2:0], ser_in};                 end
        M_SHR:  begin j_eff = {ser_in, q[WIDTH-1:1]};
                      k_eff = ~{ser_in, q[WIDTH-1:1]};                 end
        M_UP:   begin j_eff = carry_up[WIDTH-1:0];
                      k_eff = carry_up[WIDTH-1:0];                     end
        M_DOWN: begin j_eff = borrow_dn[WIDTH-1:0];
                      k_eff = borrow_dn[WIDTH-1:0];                    end
        M_TOG:  begin j_eff = '1;             k_eff = '1;              end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_universal_register_bit u_bit (
      .clk     (clk),
      .reset   (reset),
      .rst_val (RESET_VALUE[i]),
      .j       (j_eff[i]),
      .k       (k_eff[i]),
      .q       (q[i])
    );
  end

  assign q_bar = ~q;
  assign tc    = ((mode == M_UP) && carry_up[WIDTH]) ||
                 ((mode == M_DOWN) && borrow_dn[WIDTH]);

  // tc already implies a count mode, so a wrap is simply en & tc; set beats clear.
  always_comb begin
    ovf_d = ovf_q;
    if (en && tc)   ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
endmodule

// File: tb/tb_jk_universal_register.sv
// Randomized bench for jk_universal_register with an arithmetic reference model
// compared every cycle, plus directed literal checks that pin the model.

module tb_jk_universal_register;
  localparam int W = 8;
  localparam logic [W-1:0] RV = 8'hA5;

  logic clk = 1'b0;
  logic reset, en, ser_in, clr_ovf;
  logic [2:0] mode;
  logic [W-1:0] j, k, d, q, q_bar;
  logic tc, ovf;

  int passed = 0;
  int total  = 0;
  bit model_valid = 1'b0;

  logic [W-1:0] q_m;
  logic ovf_m;

  jk_universal_register #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j), .k(k), .d(d),
    .ser_in(ser_in), .clr_ovf(clr_ovf), .q(q), .q_bar(q_bar), .tc(tc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  function automatic logic tc_of(input logic [2:0] m, input logic [W-1:0] v);
    return (m == 3'd5 && v == {W{1'b1}}) || (m == 3'd6 && v == '0);
  endfunction

  // Reference model: each mode computed directly from its arithmetic meaning.
  always @(posedge clk) begin
    logic [W-1:0] nq;
    logic wrap;
    if (!reset) begin
      q_m <= RV;
      ovf_m <= 1'b0;
      model_valid <= 1'b1;
    end else if (model_valid) begin
      nq = q_m;
      wrap = 1'b0;
      if (en) begin
        case (mode)
          3'd1: for (int i = 0; i < W; i++)
                  case ({j[i], k[i]})
                    2'b01: nq[i] = 1'b0;
                    2'b10: nq[i] = 1'b1;
                    2'b11: nq[i] = ~q_m[i];
                    default: ;
                  endcase
          3'd2: nq = d;
          3'd3: nq = W'((q_m << 1) | ser_in);
          3'd4: nq = (q_m >> 1) | (W'(ser_in) << (W - 1));
          3'd5: begin nq = W'(q_m + 1); wrap = (q_m == {W{1'b1}}); end
          3'd6: begin nq = W'(q_m - 1); wrap = (q_m == '0); end
          3'd7: nq = ~q_m;
          default: ;
        endcase
      end
      q_m <= nq;
      if (wrap) ovf_m <= 1'b1;
      else if (clr_ovf) ovf_m <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("cyc_q", q, q_m);
      chk("cyc_q_bar", q_bar, ~q_m);
      chk("cyc_tc", W'(tc), W'(tc_of(mode, q_m)));
      chk("cyc_ovf", W'(ovf), W'(ovf_m));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] m, input logic [W-1:0] dv = '0, input logic si = 1'b0);
    en = 1'b1; mode = m; d = dv; ser_in = si; clr_ovf = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; mode = 3'd5; j = '0; k = '0; d = '0;
    ser_in = 1'b0; clr_ovf = 1'b0;

    // Reset held for 2 edges while counting is requested
    step(); step();
    chk("rst_q", q, 8'hA5);
    chk("rst_q_bar", q_bar, 8'h5A);
    chk("rst_ovf", W'(ovf), 8'h00);
    reset = 1'b1;
    step();
    chk("first_count", q, 8'hA6);

    // JK per-bit rule
    op(3'd2, 8'h0F);
    en = 1'b1; mode = 3'd1; j = 8'hF0; k = 8'h3C;
    step();
    chk("jk_result", q, 8'hF3);

    // Shift and enable hold
    op(3'd2, 8'h81);
    op(3'd3, '0, 1'b0);
    chk("shl", q, 8'h02);
    op(3'd4, '0, 1'b1);
    chk("shr", q, 8'h81);
    en = 1'b0; mode = 3'd7;
    step(); step(); step();
    chk("en_hold", q, 8'h81);

    // Count up wrap, sticky ovf, set beats clear
    op(3'd2, 8'hFE);
    op(3'd5);
    chk("up_ff", q, 8'hFF);
    chk("up_tc", W'(tc), 8'h01);
    op(3'd5);
    chk("up_wrap", q, 8'h00);
    chk("up_ovf", W'(ovf), 8'h01);
    chk("up_tc0", W'(tc), 8'h00);
    op(3'd2, 8'hFF);
    en = 1'b1; mode = 3'd5; clr_ovf = 1'b1;
    step();
    chk("set_wins_q", q, 8'h00);
    chk("set_wins_ovf", W'(ovf), 8'h01);
    en = 1'b0; clr_ovf = 1'b1;
    step();
    chk("clr_ovf", W'(ovf), 8'h00);

    // Count down wrap then toggle
    op(3'd2, 8'h01);
    op(3'd6);
    chk("dn_zero", q, 8'h00);
    chk("dn_tc", W'(tc), 8'h01);
    op(3'd6);
    chk("dn_wrap", q, 8'hFF);
    chk("dn_ovf", W'(ovf), 8'h01);
    op(3'd7);
    chk("toggle", q, 8'h00);

    // Reset mid-count overrides en and clr_ovf
    op(3'd2, 8'h7F);
    reset = 1'b0; en = 1'b0; mode = 3'd5; clr_ovf = 1'b1;
    step();
    chk("mid_rst_q", q, 8'hA5);
    chk("mid_rst_ovf", W'(ovf), 8'h00);
    reset = 1'b1; clr_ovf = 1'b0;

    // Randomized phase, loads biased toward counter boundaries
    for (int n = 0; n < 3000; n++) begin
      reset   = ($urandom_range(0, 99) != 0);
      en      = ($urandom_range(0, 9) != 0);
      mode    = 3'($urandom_range(0, 7));
      j       = W'($urandom);
      k       = W'($urandom);
      case ($urandom_range(0, 3))
        0: d = 8'hFF;
        1: d = 8'h00;
        2: d = 8'hFE;
        default: d = W'($urandom);
      endcase
      ser_in  = 1'($urandom);
      clr_ovf = ($urandom_range(0, 7) == 0);
      step();
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/jk_universal_register.md
Name: jk_universal_register

Overview:
- Parametrised, WIDTH-bit register bank built on per-bit JK flip-flop semantics.
- Extends the single-bit JK element with these modes: parallel load, bidirectional serial shift, up/down counting and global toggle.
- Adds enable, terminal-count and sticky-overflow status.
- Used as the general-purpose state/count register in the lab datapath, replacing arrays of discrete single-bit flip-flops.

Parameters:
WIDTH, 8, number of register bits (>=2)
RESET_VALUE, 0, value loaded into q on reset (WIDTH bits)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
en  input  1  clock enable; 0 = hold everything except reset and clr_ovf
mode  input  3  operation select (see Behaviour)
j  input  WIDTH  per-bit J inputs (mode 001)
k  input  WIDTH  per-bit K inputs (mode 001)
d  input  WIDTH  parallel load data (mode 010)
ser_in  input  1  serial input for shift modes
clr_ovf  input  1  synchronous clear of ovf
q  output  WIDTH  register state
q_bar  output  WIDTH  bitwise complement of q, combinational
tc  output  1  terminal count, combinational
ovf  output  1  sticky wrap flag, registered

Behaviour:
- All state updates occur on the rising edge of clk.
- Priority order: reset, then en, then mode.
- Reset (reset=0 at the edge): q <= RESET_VALUE and ovf <= 0, regardless of en, mode or clr_ovf. q_bar follows q.
- en=0: q holds; ovf holds, except that clr_ovf=1 still clears it.
- en=1, mode decode (one-cycle latency, result visible after the edge):
  - 000 hold: q <= q.
  - 001 JK: for each bit i, jk 00 holds, 01 -> 0, 10 -> 1, 11 toggles. Bits are independent.
  - 010 load: q <= d.
  - 011 shift left: q <= {q[WIDTH-2:0], ser_in}. The MSB is discarded.
  - 100 shift right: q <= {ser_in, q[WIDTH-1:1]}. The LSB is discarded.
  - 101 count up: q <= q+1, modulo 2^WIDTH. All-ones wraps to 0.
  - 110 count down: q <= q-1, modulo 2^WIDTH. Zero wraps to all-ones.
  - 111 toggle all: q <= ~q.
- tc (combinational):
  - 1 when mode=101 and q is all-ones.
  - 1 when mode=110 and q=0.
  - Otherwise 0.
  - tc does not depend on en.
- ovf:
  - Set to 1 on any edge where en=1, tc=1 and the mode is a count mode (a wrap occurs).
  - Cleared on an edge with clr_ovf=1 and no wrap.
  - If a wrap and clr_ovf=1 happen on the same edge, set wins (ovf=1).
  - Otherwise ovf holds.
- Mode changes take effect on the next edge. No pipeline state exists, so switching modes mid-count carries no penalty.
- Reset asserted mid-count or mid-shift returns to RESET_VALUE on that edge. The first operation after release happens on the first edge with reset=1.
- Arithmetic is unsigned WIDTH-bit. No carry output beyond tc/ovf.
- No X propagation: all mode codes are defined.

Test Plan:
- Reset, WIDTH=8, RESET_VALUE=8'hA5: hold reset=0 for 2 edges with en=1, mode=101 -> q=A5, q_bar=5A, ovf=0. Release, then 1 edge -> q=A6.
- JK mode, q=8'h0F, j=8'hF0, k=8'h3C: apply 1 edge -> bits 7-6 set, 5-4 toggle, 3-2 reset, 1-0 hold. Check against the per-bit JK rule bit by bit.
- Shift: load 8'h81, then shift left with ser_in=0, 1 edge -> 02. Shift right with ser_in=1, 1 edge -> 81. Drop en for 3 edges -> q stays 81.
- Count up from FE: edge -> FF with tc=1; edge -> 00 with ovf=1, tc=0. Then clr_ovf=1 simultaneous with another wrap (FF->00) -> ovf stays 1. clr_ovf alone -> ovf=0.
- Count down from 01: edge -> 00, tc=1; edge -> FF, ovf=1. Switch to mode 111 -> q=00 after 1 edge.
- Reset mid-operation: assert reset=0 during count-up at q=7F -> q=RESET_VALUE and ovf=0 next edge, regardless of clr_ovf and en.
